pipeline_sequencer: RTL and testbench

Sequences the fetch/decode path of the 16-bit processor. Watches the decoded instruction from `control_unit` and the execute-stage state, then drives `PC_source`/`PC_offset` into `IR_fetch` for taken branches. It also generates the fetch stall and decode flush for load-use hazards, branch shadows and memory wait states. It sits between `control_unit` and `IR_fetch` and is the only driver of their redirect and stall controls.

---
 rtl/pipeline_seq_pkg.sv | 26 ++
 rtl/pipeline_sequencer_if.sv | 32 +++
 rtl/branch_cond_eval.sv | 27 ++
 rtl/pipeline_sequencer.sv | 95 +++++++++
 tb/tb_pipeline_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_seq_pkg.sv
// Shared encodings for the fetch/decode sequencer: state values, branch
// condition codes and the bit positions of the registered ALU flags.
package pipeline_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_t;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_LT = 4'd3;
    localparam logic [3:0] COND_GE = 4'd4;
    localparam logic [3:0] COND_CS = 4'd5;
    localparam logic [3:0] COND_CC = 4'd6;
    localparam logic [3:0] COND_MI = 4'd7;
    localparam logic [3:0] COND_PL = 4'd8;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Decode-side inputs and fetch/decode control outputs of the sequencer.
interface pipeline_sequencer_if;
    // Level-sampled controls, no valid/ready: every input is sampled on each
    // rising clock edge; hold=1 means the instruction memory is not ready and
    // the sequencer must not advance. Outputs are registered levels.
    logic        hold;
    logic        branch_d;
    logic [3:0]  branch_condition_d;
    logic [11:0] branch_offset_d;
    logic [3:0]  flags;
    logic [2:0]  reg_read_adr1;
    logic [2:0]  reg_read_adr2;
    logic        mem_to_reg_e;
    logic [2:0]  reg_write_adr_e;
    logic        PC_source;
    logic [11:0] PC_offset;
    logic        stall_f;
    logic        flush_d;
    logic [1:0]  seq_state;

    modport master (
        output hold, branch_d, branch_condition_d, branch_offset_d, flags,
               reg_read_adr1, reg_read_adr2, mem_to_reg_e, reg_write_adr_e,
        input  PC_source, PC_offset, stall_f, flush_d, seq_state
    );

    modport slave (
        input  hold, branch_d, branch_condition_d, branch_offset_d, flags,
               reg_read_adr1, reg_read_adr2, mem_to_reg_e, reg_write_adr_e,
        output PC_source, PC_offset, stall_f, flush_d, seq_state
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: condition code and {Z,N,C,V}
// flags in, taken out. Codes 9..15 are never taken.
module branch_cond_eval
    import pipeline_seq_pkg::*;
(
    input  logic [3:0] branch_condition_d,
    input  logic [3:0] flags,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch_condition_d)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = flags[FLAG_Z];
            COND_NE: taken = !flags[FLAG_Z];
            COND_LT: taken = flags[FLAG_N] ^ flags[FLAG_V];
            COND_GE: taken = !(flags[FLAG_N] ^ flags[FLAG_V]);
            COND_CS: taken = flags[FLAG_C];
            COND_CC: taken = !flags[FLAG_C];
            COND_MI: taken = flags[FLAG_N];
            COND_PL: taken = !flags[FLAG_N];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Fetch/decode sequencer: redirects IR_fetch on taken branches and generates
// the fetch stall and decode flush for load-use hazards and branch shadows.
module pipeline_sequencer
    import pipeline_seq_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input logic                 clock,
    input logic                 reset,
    pipeline_sequencer_if.slave bus
);

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    seq_state_t  state;
    logic [2:0]  flush_cnt;
    logic        redirect_pending;
    logic        pc_source_q;
    logic [11:0] pc_offset_q;
    logic        stall_q;
    logic        flush_q;
    logic        taken;
    logic        hazard;
    logic        take_branch;

    branch_cond_eval u_cond (
        .branch_condition_d (bus.branch_condition_d),
        .flags              (bus.flags),
        .taken              (taken)
    );

    assign hazard = bus.mem_to_reg_e &&
                    (bus.reg_write_adr_e == bus.reg_read_adr1 ||
                     bus.reg_write_adr_e == bus.reg_read_adr2);

    // A branch deferred by a stall resolves on the stall's exit edge.
    assign take_branch = bus.branch_d && taken &&
                         ((state == ST_RUN && !hazard) || state == ST_STALL);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_RUN;
            flush_cnt        <= 3'd0;
            redirect_pending <= 1'b0;
            pc_source_q      <= 1'b0;
            pc_offset_q      <= 12'd0;
            stall_q          <= 1'b0;
            flush_q          <= 1'b0;
        end else if (bus.hold) begin
            stall_q     <= 1'b1;
            pc_source_q <= 1'b0;
        end else begin
            stall_q <= 1'b0;
            flush_q <= 1'b0;
            // A redirect counts as taken by IR_fetch once it was presented
            // through a non-held cycle; a held one is presented again.
            redirect_pending <= redirect_pending && !pc_source_q;
            pc_source_q      <= redirect_pending && !pc_source_q;
            case (state)
                ST_RUN: begin
                    if (hazard) begin
                        state   <= ST_STALL;
                        stall_q <= 1'b1;
                        flush_q <= 1'b1;
                    end
                end
                ST_STALL: state <= ST_RUN;
                ST_FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                        flush_q   <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
            if (take_branch) begin
                state            <= ST_FLUSH;
                flush_cnt        <= CNT_LOAD;
                pc_offset_q      <= bus.branch_offset_d;
                pc_source_q      <= 1'b1;
                redirect_pending <= 1'b1;
                flush_q          <= 1'b1;
            end
        end
    end

    assign bus.PC_source = pc_source_q;
    assign bus.PC_offset = pc_offset_q;
    assign bus.stall_f   = stall_q;
    assign bus.flush_d   = flush_q;
    assign bus.seq_state = state;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: single-edge vector table, hand sequences for
// multi-cycle cases, then random stimulus against a behavioural model.
module tb_pipeline_sequencer;

    localparam int FC = 2;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    pipeline_sequencer_if bus ();

    pipeline_sequencer #(.FLUSH_CYCLES(FC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        hold;
        logic        br;
        logic [3:0]  cond;
        logic [11:0] off;
        logic [3:0]  flags;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic        ld;
        logic [2:0]  wa;
        logic        e_src;
        logic [11:0] e_off;
        logic        e_stall;
        logic        e_flush;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic hold, logic br, logic [3:0] cond,
                                logic [11:0] off, logic [3:0] flags, logic [2:0] ra1,
                                logic [2:0] ra2, logic ld, logic [2:0] wa, logic e_src,
                                logic [11:0] e_off, logic e_stall, logic e_flush,
                                logic [1:0] e_state);
        vec_t v;
        v.name = name; v.hold = hold; v.br = br; v.cond = cond; v.off = off;
        v.flags = flags; v.ra1 = ra1; v.ra2 = ra2; v.ld = ld; v.wa = wa;
        v.e_src = e_src; v.e_off = e_off; v.e_stall = e_stall;
        v.e_flush = e_flush; v.e_state = e_state;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_outs(string tag, logic src, logic [11:0] off, logic stall,
                              logic flush, logic [1:0] st);
        check({tag, ".PC_source"}, 32'(bus.PC_source), 32'(src));
        check({tag, ".PC_offset"}, 32'(bus.PC_offset), 32'(off));
        check({tag, ".stall_f"},   32'(bus.stall_f),   32'(stall));
        check({tag, ".flush_d"},   32'(bus.flush_d),   32'(flush));
        check({tag, ".seq_state"}, 32'(bus.seq_state), 32'(st));
    endtask

    task automatic clear_inputs();
        bus.hold = 0; bus.branch_d = 0; bus.branch_condition_d = 0;
        bus.branch_offset_d = 0; bus.flags = 0; bus.reg_read_adr1 = 0;
        bus.reg_read_adr2 = 0; bus.mem_to_reg_e = 0; bus.reg_write_adr_e = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        step();
    endtask

    // Behavioural model: mode 0 run, 1 stall, 2 flush; flush_left counts the
    // flush cycles still to come including the current one.
    int          m_mode;
    int          m_flush_left;
    bit          m_owed;
    bit          m_src;
    logic [11:0] m_off;
    bit          m_stall;
    bit          m_flush;

    function automatic bit cond_true(int code, logic [3:0] f);
        bit z = f[3];
        bit n = f[2];
        bit c = f[1];
        bit v = f[0];
        case (code)
            0: return 1;
            1: return z;
            2: return !z;
            3: return n != v;
            4: return n == v;
            5: return c;
            6: return !c;
            7: return n;
            8: return !n;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_flush_left = 0; m_owed = 0; m_src = 0;
        m_off = 0; m_stall = 0; m_flush = 0;
    endtask

    // Applies the rules to the inputs present at the coming edge.
    task automatic model_edge();
        bit br_taken;
        bit load_use;
        bit fire;
        if (bus.hold) begin
            m_stall = 1;
            m_src = 0;
            return;
        end
        br_taken = bus.branch_d && cond_true(int'(bus.branch_condition_d), bus.flags);
        load_use = bus.mem_to_reg_e && (bus.reg_write_adr_e == bus.reg_read_adr1 ||
                                        bus.reg_write_adr_e == bus.reg_read_adr2);
        fire = 0;
        if (m_owed && m_src) m_owed = 0;
        if (m_mode == 0) begin
            if (load_use) m_mode = 1;
            else if (br_taken) fire = 1;
        end else if (m_mode == 1) begin
            if (br_taken) fire = 1;
            else m_mode = 0;
        end else begin
            m_flush_left = m_flush_left - 1;
            if (m_flush_left == 0) m_mode = 0;
        end
        if (fire) begin
            m_mode = 2;
            m_flush_left = FC;
            m_owed = 1;
            m_off = bus.branch_offset_d;
        end
        m_src = m_owed;
        m_stall = (m_mode == 1);
        m_flush = (m_mode != 0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b0;
        clear_inputs();

        vecs.push_back(mk("idle",        0,0,4'd0,12'h000,4'h0,0,0,0,0, 0,12'h000,0,0,2'd0));
        vecs.push_back(mk("al_taken",    0,1,4'd0,12'h123,4'h0,0,0,0,0, 1,12'h123,0,1,2'd2));
        vecs.push_back(mk("eq_z1",       0,1,4'd1,12'hFFC,4'h8,0,0,0,0, 1,12'hFFC,0,1,2'd2));
        vecs.push_back(mk("eq_z0",       0,1,4'd1,12'hFFC,4'h0,0,0,0,0, 0,12'h000,0,0,2'd0));
        vecs.push_back(mk("ne_z1",       0,1,4'd2,12'h010,4'h8,0,0,0,0, 0,12'h000,0,0,2'd0));
        vecs.push_back(mk("lt_n1v0",     0,1,4'd3,12'h800,4'h4,0,0,0,0, 1,12'h800,0,1,2'd2));
        vecs.push_back(mk("ge_n1v1",     0,1,4'd4,12'h7FF,4'h5,0,0,0,0, 1,12'h7FF,0,1,2'd2));
        vecs.push_back(mk("cs_c1",       0,1,4'd5,12'h001,4'h2,0,0,0,0, 1,12'h001,0,1,2'd2));
        vecs.push_back(mk("cc_c1",       0,1,4'd6,12'h001,4'h2,0,0,0,0, 0,12'h000,0,0,2'd0));
        vecs.push_back(mk("mi_n1",       0,1,4'd7,12'hABC,4'h4,0,0,0,0, 1,12'hABC,0,1,2'd2));
        vecs.push_back(mk("pl_n1",       0,1,4'd8,12'hABC,4'h4,0,0,0,0, 0,12'h000,0,0,2'd0));
        vecs.push_back(mk("never9",      0,1,4'd9,12'h055,4'hF,0,0,0,0, 0,12'h000,0,0,2'd0));
        vecs.push_back(mk("never15",     0,1,4'd15,12'h055,4'hF,0,0,0,0, 0,12'h000,0,0,2'd0));
        vecs.push_back(mk("haz_adr1",    0,0,4'd0,12'h000,4'h0,5,1,1,5, 0,12'h000,1,1,2'd1));
        vecs.push_back(mk("haz_branch",  0,1,4'd0,12'h044,4'h0,0,3,1,3, 0,12'h000,1,1,2'd1));
        vecs.push_back(mk("load_nomatch",0,1,4'd0,12'h044,4'h0,1,2,1,3, 1,12'h044,0,1,2'd2));
        vecs.push_back(mk("hold_branch", 1,1,4'd0,12'h044,4'h0,0,0,0,0, 0,12'h000,1,0,2'd0));

        do_reset();
        check_outs("reset", 0, 12'h000, 0, 0, 2'd0);

        foreach (vecs[i]) begin
            do_reset();
            bus.hold = vecs[i].hold; bus.branch_d = vecs[i].br;
            bus.branch_condition_d = vecs[i].cond; bus.branch_offset_d = vecs[i].off;
            bus.flags = vecs[i].flags; bus.reg_read_adr1 = vecs[i].ra1;
            bus.reg_read_adr2 = vecs[i].ra2; bus.mem_to_reg_e = vecs[i].ld;
            bus.reg_write_adr_e = vecs[i].wa;
            step();
            check_outs(vecs[i].name, vecs[i].e_src, vecs[i].e_off, vecs[i].e_stall,
                       vecs[i].e_flush, vecs[i].e_state);
        end

        // Taken branch: one redirect cycle, FC flush cycles, back to RUN.
        do_reset();
        bus.branch_d = 1; bus.branch_condition_d = 4'd1; bus.flags = 4'h8;
        bus.branch_offset_d = 12'hFFC;
        step();
        check_outs("br_c1", 1, 12'hFFC, 0, 1, 2'd2);
        step();
        check_outs("br_c2", 0, 12'hFFC, 0, 1, 2'd2);
        step();
        check_outs("br_c3", 0, 12'hFFC, 0, 0, 2'd0);

        // Hazard plus branch: stall first, redirect on the following cycle.
        do_reset();
        bus.mem_to_reg_e = 1; bus.reg_write_adr_e = 3; bus.reg_read_adr2 = 3;
        bus.branch_d = 1; bus.branch_condition_d = 4'd0; bus.branch_offset_d = 12'h0A5;
        step();
        check_outs("hb_c1", 0, 12'h000, 1, 1, 2'd1);
        bus.mem_to_reg_e = 0;
        step();
        check_outs("hb_c2", 1, 12'h0A5, 0, 1, 2'd2);
        bus.branch_d = 0;
        step();
        check_outs("hb_c3", 0, 12'h0A5, 0, 1, 2'd2);
        step();
        check_outs("hb_c4", 0, 12'h0A5, 0, 0, 2'd0);

        // Branch held off by hold for three cycles.
        do_reset();
        bus.hold = 1; bus.branch_d = 1; bus.branch_condition_d = 4'd0;
        bus.branch_offset_d = 12'h055;
        for (int k = 0; k < 3; k++) begin
            step();
            check_outs("hold_c", 0, 12'h000, 1, 0, 2'd0);
        end
        bus.hold = 0;
        step();
        check_outs("hold_rel", 1, 12'h055, 0, 1, 2'd2);

        // Reset in the second flush cycle clears outputs before the next edge.
        do_reset();
        bus.branch_d = 1; bus.branch_condition_d = 4'd0; bus.branch_offset_d = 12'h321;
        step();
        bus.branch_d = 0;
        step();
        check_outs("pre_rst", 0, 12'h321, 0, 1, 2'd2);
        #2 reset = 1'b1;
        #1;
        check_outs("mid_rst", 0, 12'h000, 0, 0, 2'd0);
        #3 reset = 1'b0;

        // Random stimulus against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.hold = ($urandom_range(0, 4) == 0);
            bus.branch_d = ($urandom_range(0, 2) != 0);
            bus.branch_condition_d = 4'($urandom_range(0, 15));
            bus.branch_offset_d = 12'($urandom);
            bus.flags = 4'($urandom);
            bus.reg_read_adr1 = 3'($urandom);
            bus.reg_read_adr2 = 3'($urandom);
            bus.mem_to_reg_e = ($urandom_range(0, 3) == 0);
            bus.reg_write_adr_e = 3'($urandom);
            model_edge();
            step();
            check_outs("rand", m_src, m_off, m_stall, m_flush, 2'(m_mode));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
